fifo_uart_tx: RTL

- Downstream drain stage for fifo_memory, the 8-bit FIFO.
- Pops one byte at a time through the FIFO read port whenever the FIFO is non-empty.
- Serialises each byte as an 8N1 UART frame on a single output line.
- Turns the buffered byte stream into the chip's serial debug/telemetry output.

---
 rtl/fifo_uart_tx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage for the 8-bit FIFO. Pops one byte whenever the FIFO is
// non-empty and sends it as an 8N1 UART frame on tx (LSB first, idle high).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   RD_LATENCY    cycles from the edge sampling read_enable=1 to valid fifo_data (1..4)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   fifo_empty   FIFO empty flag, sampled only while idle
//   fifo_data    FIFO read data
//   read_enable  one-cycle FIFO pop strobe (registered)
//   tx           serial line, idle high (registered)
//   busy         high whenever a frame is being fetched or sent (registered)
//   tx_done      one-cycle pulse in the last cycle of the stop bit (registered)
//
// Optional build macro FIFO_UART_TX_PARITY_EN inserts an even-parity bit between the
// last data bit and the stop bit (8E1, 11 bit periods per frame).

`timescale 1ns / 1ps

module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       read_enable,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] BaudPre  = CntW'(CLKS_PER_BIT - 2);
  localparam logic [1:0]      WaitLast = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StStart,
    StData,
`ifdef FIFO_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_t;

  state_t          state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [1:0]      wait_cnt_q;
  logic [7:0]      shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            parity_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      wait_cnt_q  <= '0;
      shift_q     <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
      read_enable <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Counters are cleared here so every frame starts from the same phase.
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
          wait_cnt_q <= '0;
          tx         <= 1'b1;
          if (!fifo_empty) begin
            read_enable <= 1'b1;
            busy        <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          read_enable <= 1'b0;
          state_q     <= StWait;
        end
        StWait: begin
          // The FIFO sampled the pop on the edge leaving StFetch; data is ready
          // RD_LATENCY edges after that.
          if (wait_cnt_q == WaitLast) begin
            shift_q    <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= ^fifo_data;
`endif
            wait_cnt_q <= '0;
            tx         <= 1'b0;
            state_q    <= StStart;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        StStart: begin
          if (baud_cnt_q == BaudLast) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx         <= shift_q[0];
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (baud_cnt_q == BaudLast) begin
            baud_cnt_q <= '0;
            shift_q    <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= parity_q;
              state_q <= StParity;
`else
              tx      <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx        <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        StParity: begin
          if (baud_cnt_q == BaudLast) begin
            baud_cnt_q <= '0;
            tx         <= 1'b1;
            state_q    <= StStop;
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
`endif
        StStop: begin
          // Raised one edge early so the registered pulse covers the final stop cycle.
          if (baud_cnt_q == BaudPre) begin
            tx_done <= 1'b1;
          end
          if (baud_cnt_q == BaudLast) begin
            baud_cnt_q <= '0;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        default: begin
          read_enable <= 1'b0;
          busy        <= 1'b0;
          tx          <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

endmodule
